// File: rtl/hit_timer_pkg.sv
// Shared types and default frame delays for the hit / respawn timing path.
package hit_timer_pkg;

  typedef enum logic [1:0] {
    WATCH   = 2'd0,
    HIT_DLY = 2'd1,
    RSP_DLY = 2'd2,
    GRACE   = 2'd3
  } hit_state_t;

  // Defaults tuned for the 60 Hz frame rate game control runs at.
  localparam int DEF_HIT_DELAY_FRAMES     = 60;
  localparam int DEF_RESPAWN_DELAY_FRAMES = 30;
  localparam int DEF_GRACE_FRAMES         = 90;
  localparam int DEF_CNT_W                = 8;

  function automatic int min1(input int frames);
    return (frames < 1) ? 1 : frames;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame countdown; expire flags the frame boundary on which the value is 1.
module frame_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count parks at 1 (or 0 after reset) and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (sof && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = sof && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hit_event_timer.sv
// Turns frame-level collisions into charHit and paces the lose-a-life / respawn counter pulses.
module hit_event_timer
  import hit_timer_pkg::*;
#(
  parameter int HIT_DELAY_FRAMES     = DEF_HIT_DELAY_FRAMES,
  parameter int RESPAWN_DELAY_FRAMES = DEF_RESPAWN_DELAY_FRAMES,
  parameter int GRACE_FRAMES         = DEF_GRACE_FRAMES,
  parameter int CNT_W                = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             collision,
  input  logic             charStart,
  output logic             charHit,
  output logic             counter,
  output logic             busy,
  output logic             graceActive,
  output hit_state_t       dbg_state,
  output logic [CNT_W-1:0] dbg_frame_cnt,
  output logic             dbg_coll_seen
);

  localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(min1(HIT_DELAY_FRAMES));
  localparam logic [CNT_W-1:0] RSP_LOAD   = CNT_W'(min1(RESPAWN_DELAY_FRAMES));
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_FRAMES);
  localparam bit               SKIP_GRACE = (GRACE_FRAMES == 0);

  hit_state_t       state_q, state_d;
  logic             coll_seen_q, coll_seen_d;
  logic             char_hit_q, char_hit_d;
  logic             counter_q, counter_d;
  logic             busy_q, busy_d;
  logic             grace_q, grace_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] frame_cnt;
  logic             cnt_expire;
  logic             qual_coll;

  frame_down_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk      (clk),
    .reset    (reset),
    .sof      (startOfFrame),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (frame_cnt),
    .expire   (cnt_expire)
  );

  assign qual_coll = collision && charStart;

  always_comb begin
    state_d      = state_q;
    coll_seen_d  = 1'b0;
    char_hit_d   = 1'b0;
    counter_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      WATCH: begin
        // A collision on the frame boundary itself still belongs to the closing frame.
        coll_seen_d = charStart && (coll_seen_q || collision);
        if (startOfFrame) begin
          coll_seen_d = 1'b0;
          if (charStart && (coll_seen_q || qual_coll)) begin
            char_hit_d   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HIT_LOAD;
            state_d      = HIT_DLY;
          end
        end
      end
      HIT_DLY: begin
        if (cnt_expire) begin
          counter_d    = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = RSP_LOAD;
          state_d      = RSP_DLY;
        end
      end
      RSP_DLY: begin
        if (cnt_expire) begin
          counter_d = 1'b1;
          if (SKIP_GRACE) begin
            state_d = WATCH;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = GRACE_LOAD;
            state_d      = GRACE;
          end
        end
      end
      GRACE: begin
        if (cnt_expire) begin
          state_d = WATCH;
        end
      end
      default: state_d = WATCH;
    endcase
    busy_d  = (state_d != WATCH);
    grace_d = (state_d == GRACE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WATCH;
      coll_seen_q <= 1'b0;
      char_hit_q  <= 1'b0;
      counter_q   <= 1'b0;
      busy_q      <= 1'b0;
      grace_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      coll_seen_q <= coll_seen_d;
      char_hit_q  <= char_hit_d;
      counter_q   <= counter_d;
      busy_q      <= busy_d;
      grace_q     <= grace_d;
    end
  end

  assign charHit       = char_hit_q;
  assign counter       = counter_q;
  assign busy          = busy_q;
  assign graceActive   = grace_q;
  assign dbg_state     = state_q;
  assign dbg_frame_cnt = frame_cnt;
  assign dbg_coll_seen = coll_seen_q;

endmodule

// File: tb/tb_hit_event_timer.sv
// Directed bench for hit_event_timer: 10-cycle frames, two parameter sets, pulse scoreboards.
module tb_hit_event_timer;
  import hit_timer_pkg::*;

  localparam int W = 34;
  localparam logic [1:0] K_HIT = 2'b01;
  localparam logic [1:0] K_CNT = 2'b10;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic sof   = 1'b0;
  logic col_a = 1'b0, cs_a = 1'b0, rst_a = 1'b1;
  logic col_b = 1'b0, cs_b = 1'b0, rst_b = 1'b1;
  int   phase = 0;

  logic       char_hit_a, counter_a, busy_a, grace_a, coll_seen_a;
  logic       char_hit_b, counter_b, busy_b, grace_b, coll_seen_b;
  hit_state_t state_a, state_b;
  logic [7:0] frame_cnt_a, frame_cnt_b;

  hit_event_timer #(
    .HIT_DELAY_FRAMES(3), .RESPAWN_DELAY_FRAMES(2), .GRACE_FRAMES(4), .CNT_W(8)
  ) dut_a (
    .clk(clk), .reset(rst_a), .startOfFrame(sof), .collision(col_a), .charStart(cs_a),
    .charHit(char_hit_a), .counter(counter_a), .busy(busy_a), .graceActive(grace_a),
    .dbg_state(state_a), .dbg_frame_cnt(frame_cnt_a), .dbg_coll_seen(coll_seen_a)
  );

  hit_event_timer #(
    .HIT_DELAY_FRAMES(0), .RESPAWN_DELAY_FRAMES(2), .GRACE_FRAMES(0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset(rst_b), .startOfFrame(sof), .collision(col_b), .charStart(cs_b),
    .charHit(char_hit_b), .counter(counter_b), .busy(busy_b), .graceActive(grace_b),
    .dbg_state(state_b), .dbg_frame_cnt(frame_cnt_b), .dbg_coll_seen(coll_seen_b)
  );

  // scoreboard
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] got_a, got_b;
  logic         grace_b_seen = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [W-1:0] ev(input logic [1:0] kind, input int c);
    return {kind, 32'(c)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (char_hit_a && counter_a) check("a_pulse_overlap", 1, 0);
    if (char_hit_a || counter_a) begin
      got_a = {counter_a, char_hit_a, 32'(cyc)};
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_pulse: got %0h expected none", got_a);
      end else begin
        check("a_pulse", got_a, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (grace_b) grace_b_seen = 1'b1;
    if (char_hit_b && counter_b) check("b_pulse_overlap", 1, 0);
    if (char_hit_b || counter_b) begin
      got_b = {counter_b, char_hit_b, 32'(cyc)};
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_pulse: got %0h expected none", got_b);
      end else begin
        check("b_pulse", got_b, exp_b.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input logic ca, input logic csa, input logic ra,
                      input logic cb, input logic csb, input logic rb);
    @(negedge clk);
    sof   = (phase == 0);
    phase = (phase == 9) ? 0 : phase + 1;
    col_a = ca; cs_a = csa; rst_a = ra;
    col_b = cb; cs_b = csb; rst_b = rb;
  endtask

  task automatic align();
    while (phase != 0) step(0, 0, 0, 0, 0, 0);
  endtask

  int start;

  initial begin
    repeat (3) step(0, 0, 1, 0, 0, 1);
    check("rst_char_hit", char_hit_a, 0);
    check("rst_counter", counter_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_grace", grace_a, 0);
    check("rst_state", state_a, WATCH);
    check("rst_frame_cnt", frame_cnt_a, 0);
    check("rst_coll_seen", coll_seen_a, 0);
    check("rst_b_busy", busy_b, 0);
    phase = 0;

    // Continuous collision from frame 0 through the whole sequence and past WATCH re-entry.
    for (int k = 0; k < 210; k++) begin
      step((k >= 1 && k <= 105), 1, 0, 0, 0, 0);
      if (k == 0) begin
        start = cyc;
        exp_a.push_back(ev(K_HIT, start + 11));
        exp_a.push_back(ev(K_CNT, start + 41));
        exp_a.push_back(ev(K_CNT, start + 61));
        exp_a.push_back(ev(K_HIT, start + 111));
        exp_a.push_back(ev(K_CNT, start + 141));
        exp_a.push_back(ev(K_CNT, start + 161));
      end
      if (k inside {10, 11, 60, 61, 100, 101, 110, 111, 160, 161, 200, 201}) begin
        check("s1_busy", busy_a, ((k >= 11 && k <= 100) || (k >= 111 && k <= 200)));
        check("s1_grace", grace_a, ((k >= 61 && k <= 100) || (k >= 161 && k <= 200)));
      end
      if (k == 11) check("s1_cnt_load", frame_cnt_a, 3);
      if (k == 21) check("s1_cnt_dec", frame_cnt_a, 2);
      if (k == 105) check("s1_coll_seen", coll_seen_a, 1);
    end
    check("s1_queue_empty", exp_a.size(), 0);

    // Collision only on a frame-start cycle, then reset on the cycle the first counter would fire.
    align();
    for (int k = 0; k < 100; k++) begin
      step((k == 10), 1, (k == 40), 0, 0, 0);
      if (k == 0) begin
        start = cyc;
        exp_a.push_back(ev(K_HIT, start + 11));
      end
      if (k == 39) check("s2_busy_pre_rst", busy_a, 1);
      if (k == 41) begin
        check("s2_rst_busy", busy_a, 0);
        check("s2_rst_state", state_a, WATCH);
        check("s2_rst_counter", counter_a, 0);
        check("s2_rst_frame_cnt", frame_cnt_a, 0);
      end
    end
    check("s2_queue_empty", exp_a.size(), 0);

    // Collisions while charStart is low never latch.
    align();
    for (int k = 0; k < 50; k++) begin
      step((k < 30), (k >= 30), 0, 0, 0, 0);
      if (k == 15 || k == 30) check("s3_coll_seen", coll_seen_a, 0);
      if (k == 31) check("s3_busy", busy_a, 0);
    end
    check("s3_queue_empty", exp_a.size(), 0);

    // HIT=0, GRACE=0: one-frame hit delay, RSP_DLY returns straight to WATCH.
    align();
    for (int k = 0; k < 70; k++) begin
      step(0, 0, 0, ((k >= 3 && k <= 5) || (k >= 42 && k <= 44)), 1, 0);
      if (k == 0) begin
        start = cyc;
        exp_b.push_back(ev(K_HIT, start + 11));
        exp_b.push_back(ev(K_CNT, start + 21));
        exp_b.push_back(ev(K_CNT, start + 41));
        exp_b.push_back(ev(K_HIT, start + 51));
        exp_b.push_back(ev(K_CNT, start + 61));
      end
      if (k == 11) check("s4_cnt_load_min1", frame_cnt_b, 1);
      if (k == 40) check("s4_busy_rsp", busy_b, 1);
      if (k == 41) check("s4_busy_watch", busy_b, 0);
      if (k == 41) check("s4_state_watch", state_b, WATCH);
    end
    check("s4_queue_empty", exp_b.size(), 0);
    check("s4_grace_never", grace_b_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_event_timer.md
# hit_event_timer

Produces the two event inputs the game control FSM consumes: a single-cycle `charHit` when the character collides with a bubble, and the single-cycle `counter` pulses that pace the lose-a-life and respawn sequence. It sits between the per-pixel collision logic / VGA frame timing and the game control FSM. It counts whole video frames to generate two timed delays. After respawn it runs a grace window so one overlap cannot cost two lives.

## Interface
Parameters:
- `HIT_DELAY_FRAMES`, default 60: frames from `charHit` to first `counter` pulse (end of ev_life).
- `RESPAWN_DELAY_FRAMES`, default 30: frames from first to second `counter` pulse (end of ret_game).
- `GRACE_FRAMES`, default 90: frames after second pulse during which collisions are ignored.
- `CNT_W`, default 8: frame-counter width; every delay parameter must be ≤ 2^CNT_W−1.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse, once per video frame.
- `collision` in 1: level, high on any cycle where a character pixel overlaps a bubble pixel.
- `charStart` in 1: from game control; 1 = character live and collisions meaningful.
- `charHit` out 1: one-cycle hit pulse.
- `counter` out 1: one-cycle delay-expired pulse.
- `busy` out 1: high in any state other than WATCH.
- `graceActive` out 1: high in GRACE.

## Operation
- States are WATCH, HIT_DLY, RSP_DLY and GRACE.
- Reset puts the block in WATCH. `frameCnt` = 0 and `collSeen` = 0. All outputs are 0.
- **Collision latch.** `collSeen` sets on any cycle with `collision && charStart` while in WATCH.
  - It clears on every `startOfFrame`, after it has been evaluated.
  - A `collision` on the same cycle as `startOfFrame` counts toward the frame being closed.
- **WATCH.** On `startOfFrame`, if `collSeen` (or same-cycle qualified `collision`) is set:
  - pulse `charHit`;
  - load `frameCnt` = max(HIT_DELAY_FRAMES, 1);
  - go to HIT_DLY.
  - If `charStart` = 0, collisions are ignored and `collSeen` is held at 0.
- **HIT_DLY.** Decrement `frameCnt` on each `startOfFrame`. On the `startOfFrame` where `frameCnt` = 1:
  - pulse `counter`;
  - load max(RESPAWN_DELAY_FRAMES, 1);
  - go to RSP_DLY.
- **RSP_DLY.** Same countdown. At expiry:
  - pulse `counter`;
  - if GRACE_FRAMES = 0, go directly to WATCH;
  - otherwise load GRACE_FRAMES and go to GRACE.
- **GRACE.** Collisions are ignored and `collSeen` is forced to 0. Count down on `startOfFrame`; at expiry go to WATCH with no pulse.
- Outside WATCH, `collision` has no effect.
- `charStart` has no effect on the delay states. Game control may sit in lose forever; the remaining pulses are harmless.
- Decrement never goes below 1, so there is no wrap-around.
- A delay parameter of 0 is treated as 1 frame, except GRACE_FRAMES = 0, which skips GRACE.
- `reset` asserted in any state returns to the reset condition on the next edge. A pulse asserted on that edge is not emitted.

## Timing
- `charHit` and `counter` are registered. Each is high for exactly the one cycle after the `startOfFrame` cycle that triggers it. Latency is 1 clock from `startOfFrame`.
- `charHit` and `counter` are never high together. At most one pulse is issued per frame.
- First `counter` follows `charHit` by exactly HIT_DELAY_FRAMES frames. Second `counter` follows the first by RESPAWN_DELAY_FRAMES frames.
- `busy` and `graceActive` are registered state decodes. They change in the same cycle as the corresponding pulse.
- WATCH is re-entered GRACE_FRAMES frames after the second pulse. A collision in that re-entry frame, after the transition, counts.

## Structure
- Package `hit_timer_pkg` holds:
  - `hit_state_t` enum {WATCH, HIT_DLY, RSP_DLY, GRACE};
  - default delay constants shared with game control, for the frame rate the game runs at.
- One natural sub-module, `frame_down_counter`:
  - `CNT_W`-wide counter with load/decrement-on-`startOfFrame`;
  - `expire` output asserted when value = 1 on a `startOfFrame` cycle.
  - It is instantiated once and reused across the three delay states.

## Test plan
Use HIT=3, RSP=2, GRACE=4, and a 10-cycle frame.
- Collision in frame 0, `charStart`=1 → `charHit` on the cycle after frame 1's `startOfFrame`. `counter` at frame 4 and frame 6. `graceActive` in frames 6–9. `busy` falls at frame 10.
- Collision exactly on a `startOfFrame` cycle → `charHit` the next cycle (counted toward the closing frame).
- Continuous `collision` through HIT_DLY/RSP_DLY/GRACE → exactly one `charHit`. A second `charHit` occurs one frame after WATCH re-entry.
- `collision` with `charStart`=0 in WATCH → no `charHit`, `collSeen` stays 0.
- `reset` pulsed mid-HIT_DLY → outputs 0, state WATCH, no `counter` emitted.
- HIT=0, GRACE=0 → `counter` one frame after `charHit`. RSP_DLY returns straight to WATCH; `graceActive` never asserts.
